// File: rtl/piano_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : piano_sequencer
// Purpose  : Record/playback controller between the board key switches and
//            the piano tone/segment datapath. Passes sanitized live keys in
//            IDLE/RECORD and replays a stored note/duration melody in PLAY.
//            keys_out is always one-hot or all-zero (rest).
// Ports    : clk          system clock
//            reset        synchronous active-low reset
//            keys_in[7:0] live keys {ha,g,f,e,d,c,b,a}, level
//            rec_btn      start recording (rising edge acts)
//            play_btn     start playback (rising edge acts)
//            stop_btn     stop current activity (rising edge acts)
//            keys_out     key lines to the piano/segment path
//            rec_active   high while recording
//            play_active  high while playing
//            note_count   number of stored entries
//            overflow     sticky: buffer filled during the last recording
// Options  : PIANO_SEQ_LOOP_EN - when defined, playback wraps to entry 0
//            and repeats until stop or reset.
// Revision : 1.0 - initial release
// ============================================================================
module piano_sequencer #(
  parameter int TICK_DIV = 500000,
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [7:0]                           keys_in,
  input  logic                                 rec_btn,
  input  logic                                 play_btn,
  input  logic                                 stop_btn,
  output logic [7:0]                           keys_out,
  output logic                                 rec_active,
  output logic                                 play_active,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0] note_count,
  output logic                                 overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX    = {DUR_W{1'b1}};
  localparam logic [AW:0]      CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]      CNT_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_LAST   = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0]    IDX_ONE    = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t state, state_n;

  // melody buffer, intentionally not reset
  logic [7:0]       key_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];

  logic [7:0]       keys_n;
  logic [AW:0]      cnt_n;
  logic             ovf_n;
  logic [PW-1:0]    presc, presc_n;
  logic             rec_q, play_q, stop_q;
  logic [7:0]       cur, cur_n;
  logic [DUR_W-1:0] dur, dur_n;
  logic             started, started_n;
  logic [AW-1:0]    idx, idx_n;
  logic [DUR_W-1:0] rem, rem_n;

  logic             wr_en;
  logic [7:0]       wr_key;
  logic [DUR_W-1:0] wr_dur;
  logic [AW-1:0]    wr_idx;

  logic [7:0]       skey;
  logic             tick;
  logic             rec_edge, play_edge, stop_edge;
  logic [AW-1:0]    idx_inc;
  logic [AW:0]      cnt_last;

  // x & -x isolates the lowest set bit, giving key 'a' the highest priority
  assign skey      = keys_in & (~keys_in + 8'd1);
  assign tick      = (presc == PRESC_LAST);
  assign rec_edge  = rec_btn  & ~rec_q;
  assign play_edge = play_btn & ~play_q;
  assign stop_edge = stop_btn & ~stop_q;
  assign idx_inc   = idx + IDX_ONE;
  assign cnt_last  = note_count - CNT_ONE;
  assign wr_idx    = note_count[AW-1:0];

  assign rec_active  = (state == S_RECORD);
  assign play_active = (state == S_PLAY);

  always_comb begin
    state_n   = state;
    keys_n    = keys_out;
    cnt_n     = note_count;
    ovf_n     = overflow;
    presc_n   = tick ? '0 : presc + PRESC_ONE;
    cur_n     = cur;
    dur_n     = dur;
    started_n = started;
    idx_n     = idx;
    rem_n     = rem;
    wr_en     = 1'b0;
    wr_key    = cur;
    wr_dur    = dur;

    case (state)
      S_IDLE: begin
        keys_n  = skey;
        presc_n = '0;
        // stop outranks rec outranks play; stop itself does nothing here
        if (stop_edge) begin
          state_n = S_IDLE;
        end else if (rec_edge) begin
          state_n   = S_RECORD;
          cnt_n     = '0;
          ovf_n     = 1'b0;
          started_n = 1'b0;
        end else if (play_edge && (note_count != '0)) begin
          state_n = S_PLAY;
          idx_n   = '0;
          keys_n  = key_mem[0];
          rem_n   = dur_mem[0];
        end
      end

      S_RECORD: begin
        keys_n = skey;
        if (stop_edge) begin
          if (started && (note_count < CNT_DEPTH)) begin
            wr_en = 1'b1;
            cnt_n = note_count + CNT_ONE;
          end
          started_n = 1'b0;
          state_n   = S_IDLE;
        end else if (tick) begin
          if (!started) begin
            // leading rests are skipped until the first real key
            if (skey != 8'd0) begin
              started_n = 1'b1;
              cur_n     = skey;
              dur_n     = DUR_ONE;
            end
          end else if ((skey == cur) && (dur != DUR_MAX)) begin
            dur_n = dur + DUR_ONE;
          end else begin
            // key change or saturated duration: commit and start a new segment
            wr_en = 1'b1;
            cnt_n = note_count + CNT_ONE;
            if (note_count == CNT_LAST) begin
              ovf_n     = 1'b1;
              started_n = 1'b0;
              state_n   = S_IDLE;
            end else begin
              cur_n = skey;
              dur_n = DUR_ONE;
            end
          end
        end
      end

      S_PLAY: begin
        if (stop_edge) begin
          keys_n  = '0;
          state_n = S_IDLE;
        end else if (tick) begin
          if (rem <= DUR_ONE) begin
            if ({1'b0, idx} == cnt_last) begin
`ifdef PIANO_SEQ_LOOP_EN
              idx_n  = '0;
              keys_n = key_mem[0];
              rem_n  = dur_mem[0];
`else
              keys_n  = '0;
              state_n = S_IDLE;
`endif
            end else begin
              idx_n  = idx_inc;
              keys_n = key_mem[idx_inc];
              rem_n  = dur_mem[idx_inc];
            end
          end else begin
            rem_n = rem - DUR_ONE;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        keys_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      keys_out   <= '0;
      note_count <= '0;
      overflow   <= 1'b0;
      presc      <= '0;
      rec_q      <= 1'b0;
      play_q     <= 1'b0;
      stop_q     <= 1'b0;
      cur        <= '0;
      dur        <= '0;
      started    <= 1'b0;
      idx        <= '0;
      rem        <= '0;
    end else begin
      state      <= state_n;
      keys_out   <= keys_n;
      note_count <= cnt_n;
      overflow   <= ovf_n;
      presc      <= presc_n;
      rec_q      <= rec_btn;
      play_q     <= play_btn;
      stop_q     <= stop_btn;
      cur        <= cur_n;
      dur        <= dur_n;
      started    <= started_n;
      idx        <= idx_n;
      rem        <= rem_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_idx] <= wr_key;
      dur_mem[wr_idx] <= wr_dur;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piano_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piano_sequencer
// Purpose  : Self-checking bench for piano_sequencer (TICK_DIV=4, DEPTH=4,
//            DUR_W=3). Expected melodies come from a run-length model of the
//            per-tick sanitized key stream; playback is checked cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piano_sequencer;

  localparam int TD   = 4;
  localparam int DP   = 4;
  localparam int DW   = 3;
  localparam int MAXD = 7;
`ifdef PIANO_SEQ_LOOP_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif

  typedef struct {
    logic [7:0] k;
    int         d;
  } ent_t;

  typedef struct {
    logic [7:0] in;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] keys_in = 8'h00;
  logic       rec_btn = 1'b0;
  logic       play_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [7:0] keys_out;
  logic       rec_active;
  logic       play_active;
  logic [2:0] note_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] seg_k[$];
  int         seg_n[$];
  logic [7:0] tick_q[$];
  ent_t       exp_q[$];
  int         exp_cnt;
  logic       exp_ovf;

  vec_t vecs[7];

  always #5 clk = ~clk;

  piano_sequencer #(
    .TICK_DIV(TD),
    .DEPTH(DP),
    .DUR_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys_in(keys_in),
    .rec_btn(rec_btn),
    .play_btn(play_btn),
    .stop_btn(stop_btn),
    .keys_out(keys_out),
    .rec_active(rec_active),
    .play_active(play_active),
    .note_count(note_count),
    .overflow(overflow)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lowbit(input logic [7:0] k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) if (k[i]) r = 8'h01 << i;
    return r;
  endfunction

  // Run-length model: drop leading rests, split runs longer than MAXD,
  // and the last chunk is committed only by stop unless the buffer filled.
  task automatic model();
    ent_t chunks[$];
    int p, l, c;
    logic [7:0] k;
    chunks.delete();
    exp_q.delete();
    p = 0;
    while (p < tick_q.size() && tick_q[p] == 8'h00) p++;
    while (p < tick_q.size()) begin
      k = tick_q[p];
      l = 0;
      while (p < tick_q.size() && tick_q[p] == k) begin
        l++;
        p++;
      end
      while (l > MAXD) begin
        chunks.push_back(ent_t'{k, MAXD});
        l -= MAXD;
      end
      chunks.push_back(ent_t'{k, l});
    end
    c = chunks.size();
    if (c - 1 >= DP) begin
      exp_ovf = 1'b1;
      exp_cnt = DP;
    end else begin
      exp_ovf = 1'b0;
      exp_cnt = c;
    end
    for (int i = 0; i < exp_cnt; i++) exp_q.push_back(chunks[i]);
  endtask

  task automatic run_record();
    tick_q.delete();
    foreach (seg_k[i]) for (int n = 0; n < seg_n[i]; n++) tick_q.push_back(lowbit(seg_k[i]));
    model();
    keys_in = 8'h00;
    rec_btn = 1'b1;
    step();
    rec_btn = 1'b0;
    chk("rec_enter", rec_active, 1);
    chk("rec_enter_cnt", note_count, 0);
    chk("rec_enter_ovf", overflow, 0);
    foreach (seg_k[i]) begin
      keys_in = seg_k[i];
      repeat (seg_n[i] * TD) step();
    end
    chk("rec_live_before_stop", rec_active, !exp_ovf);
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    keys_in  = 8'h00;
    step();
    chk("rec_exit", rec_active, 0);
    chk("rec_count", note_count, exp_cnt);
    chk("rec_overflow", overflow, exp_ovf);
  endtask

  task automatic run_play(input int passes);
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    for (int p = 0; p < passes; p++) begin
      foreach (exp_q[j]) begin
        for (int c = 0; c < exp_q[j].d * TD; c++) begin
          chk("play_key", keys_out, exp_q[j].k);
          if (c == 0) chk("play_active", play_active, 1);
          step();
        end
      end
    end
`ifdef PIANO_SEQ_LOOP_EN
    chk("loop_wrap_key", keys_out, exp_q[0].k);
    chk("loop_active", play_active, 1);
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
`endif
    chk("play_end_key", keys_out, 0);
    chk("play_end_active", play_active, 0);
    step();
  endtask

  initial begin
    vecs[0] = '{8'h06, 8'h02};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'h80, 8'h80};
    vecs[3] = '{8'hFF, 8'h01};
    vecs[4] = '{8'h0C, 8'h04};
    vecs[5] = '{8'hA0, 8'h20};
    vecs[6] = '{8'h41, 8'h01};

    // reset
    step();
    step();
    chk("reset_keys", keys_out, 0);
    chk("reset_rec", rec_active, 0);
    chk("reset_play", play_active, 0);
    chk("reset_cnt", note_count, 0);
    chk("reset_ovf", overflow, 0);
    keys_in = 8'h06;
    step();
    chk("reset_holds_keys", keys_out, 0);
    reset = 1'b1;

    // IDLE passthrough table
    for (int i = 0; i < 7; i++) begin
      keys_in = vecs[i].in;
      step();
      chk("passthru_vec", keys_out, vecs[i].exp);
    end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      keys_in = r;
      step();
      chk("passthru_rand", keys_out, lowbit(r));
    end
    keys_in = 8'h00;
    step();

    // play with an empty buffer is ignored
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    chk("play_empty_ignored", play_active, 0);
    step();

    // stop outranks rec in the same cycle
    rec_btn  = 1'b1;
    stop_btn = 1'b1;
    step();
    rec_btn  = 1'b0;
    stop_btn = 1'b0;
    chk("rec_stop_priority", rec_active, 0);
    step();

    // reference melody
    seg_k = '{8'h04, 8'h00, 8'h10};
    seg_n = '{3, 1, 2};
    run_record();
    chk("melody_cnt", note_count, 3);
    exp_q = '{ent_t'{8'h04, 3}, ent_t'{8'h00, 1}, ent_t'{8'h10, 2}};
    run_play(PASSES);

    // duration saturation splits the note
    seg_k = '{8'h01};
    seg_n = '{9};
    run_record();
    chk("sat_cnt", note_count, 2);
    exp_q = '{ent_t'{8'h01, 7}, ent_t'{8'h01, 2}};
    run_play(PASSES);

    // overflow
    seg_k = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01};
    seg_n = '{1, 1, 1, 1, 1};
    run_record();
    chk("ovf_cnt", note_count, 4);
    chk("ovf_flag", overflow, 1);
    exp_q = '{ent_t'{8'h01, 1}, ent_t'{8'h02, 1}, ent_t'{8'h01, 1}, ent_t'{8'h02, 1}};
    run_play(PASSES);

    // stop mid-play
    seg_k = '{8'h08};
    seg_n = '{3};
    run_record();
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    repeat (5) step();
    chk("midplay_active", play_active, 1);
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    chk("stop_play_key", keys_out, 0);
    chk("stop_play_active", play_active, 0);
    step();

    // reset mid-record loses the recording
    rec_btn = 1'b1;
    step();
    rec_btn = 1'b0;
    keys_in = 8'h02;
    repeat (3 * TD + 2) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    keys_in = 8'h00;
    chk("rst_rec_cnt", note_count, 0);
    chk("rst_rec_active", rec_active, 0);
    step();

    // two-entry melody (wraps when looping is enabled)
    seg_k = '{8'h02, 8'h20};
    seg_n = '{1, 2};
    run_record();
    exp_q = '{ent_t'{8'h02, 1}, ent_t'{8'h20, 2}};
    run_play(PASSES);

    // randomized melodies against the run-length model
    for (int it = 0; it < 10; it++) begin
      int ns;
      logic [7:0] prev;
      seg_k.delete();
      seg_n.delete();
      ns   = $urandom_range(1, 6);
      prev = 8'h00;
      for (int s = 0; s < ns; s++) begin
        logic [7:0] k;
        case ($urandom_range(0, 3))
          0:       k = 8'h00;
          1:       k = prev;
          default: k = 8'($urandom_range(1, 255));
        endcase
        seg_k.push_back(k);
        seg_n.push_back($urandom_range(1, 9));
        prev = k;
      end
      run_record();
      if (exp_cnt > 0) begin
        run_play(PASSES);
      end else begin
        play_btn = 1'b1;
        step();
        play_btn = 1'b0;
        chk("rand_empty_play", play_active, 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
